memory_access_stage: RTL and testbench

Pipeline MEM stage between execute and writeback. It drives the single-port data cache's master interface, and the cache's single-cycle registered read. It turns RISC-V load/store ops into word-aligned accesses with byte enables and lane-placed store data. Load data is extracted and sign/zero-extended. Non-memory ops pass through to writeback under a valid/ready handshake.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/load_align.sv | 26 ++
 rtl/memory_access_stage.sv | 157 +++++++++++++++
 tb/tb_memory_access_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 size codes, FSM states
// and the store byte-enable helper.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_LOAD_DATA = 2'd2
    } mem_state_t;

    function automatic logic [3:0] byte_enable_for(input logic [2:0] funct3,
                                                   input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << offset;
            F3_H:    be = 4'b0011 << offset;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a cache word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_read_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_read_data[{i_offset, 3'b000} +: 8];
        w_half = i_read_data[{i_offset[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_BU:   o_result = {24'd0, w_byte};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = i_read_data;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: drives the single-port data cache for loads/stores and
// forwards every op (or its fault) to writeback through a one-entry output register.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_write_rd,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_enable,
    output logic [3:0]            mem_byte_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_write_rd,
    output logic                  out_fault
);

    mem_state_t r_state;
    logic [4:0] r_rd;
    logic [2:0] r_funct3;
    logic [1:0] r_offset;
    logic       r_is_store;

    logic                  w_is_mem;
    logic                  w_f3_legal;
    logic                  w_misaligned;
    logic                  w_fault;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_store_lanes;
    logic [DATA_WIDTH-1:0] w_load_value;

    assign in_ready = (r_state == ST_IDLE) && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mem = in_is_load || in_is_store;

    always_comb begin
        w_f3_legal = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_f3_legal = 1'b1;
                default:                        w_f3_legal = 1'b0;
            endcase
        end else if (in_is_store) begin
            case (in_funct3)
                F3_B, F3_H, F3_W: w_f3_legal = 1'b1;
                default:          w_f3_legal = 1'b0;
            endcase
        end
    end

    // funct3[1:0] carries the access size for every legal code (01 half, 10 word)
    assign w_misaligned = ((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                          ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00));
    assign w_fault      = w_is_mem && (!w_f3_legal || w_misaligned);

    always_comb begin
        case (in_funct3)
            F3_B:    w_store_lanes = {4{in_store_data[7:0]}};
            F3_H:    w_store_lanes = {2{in_store_data[15:0]}};
            default: w_store_lanes = in_store_data;
        endcase
    end

    load_align u_load_align (
        .i_read_data (mem_read_data),
        .i_funct3    (r_funct3),
        .i_offset    (r_offset),
        .o_result    (w_load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_rd            <= '0;
            r_funct3        <= '0;
            r_offset        <= '0;
            r_is_store      <= 1'b0;
            mem_address     <= '0;
            mem_enable      <= 1'b0;
            mem_byte_enable <= '0;
            mem_write_data  <= '0;
            out_valid       <= 1'b0;
            out_rd          <= '0;
            out_result      <= '0;
            out_write_rd    <= 1'b0;
            out_fault       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem && !w_fault) begin
                            r_state     <= ST_ACCESS;
                            r_rd        <= in_rd;
                            r_funct3    <= in_funct3;
                            r_offset    <= in_alu_result[1:0];
                            r_is_store  <= in_is_store;
                            mem_address <= {in_alu_result[ADDR_WIDTH-1:2], 2'b00};
                            if (in_is_store) begin
                                mem_enable      <= 1'b1;
                                mem_byte_enable <= byte_enable_for(in_funct3, in_alu_result[1:0]);
                                mem_write_data  <= w_store_lanes;
                            end
                        end else begin
                            out_valid    <= 1'b1;
                            out_rd       <= in_rd;
                            out_result   <= in_alu_result;
                            out_write_rd <= in_write_rd && !w_is_mem;
                            out_fault    <= w_fault;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_is_store) begin
                        mem_enable      <= 1'b0;
                        mem_byte_enable <= '0;
                        out_valid       <= 1'b1;
                        out_rd          <= r_rd;
                        out_result      <= '0;
                        out_write_rd    <= 1'b0;
                        out_fault       <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOAD_DATA;
                    end
                end
                ST_LOAD_DATA: begin
                    out_valid    <= 1'b1;
                    out_rd       <= r_rd;
                    out_result   <= w_load_value;
                    out_write_rd <= 1'b1;
                    out_fault    <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a small registered-read cache model
// and a scoreboard of expected writeback results.
module tb_memory_access_stage;

    localparam int PERIOD = 10;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_write_rd;
    logic [31:0] mem_address;
    logic        mem_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_write_rd;
    logic        out_fault;

    memory_access_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_is_load      (in_is_load),
        .in_is_store     (in_is_store),
        .in_funct3       (in_funct3),
        .in_alu_result   (in_alu_result),
        .in_store_data   (in_store_data),
        .in_rd           (in_rd),
        .in_write_rd     (in_write_rd),
        .mem_address     (mem_address),
        .mem_enable      (mem_enable),
        .mem_byte_enable (mem_byte_enable),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_rd          (out_rd),
        .out_result      (out_result),
        .out_write_rd    (out_write_rd),
        .out_fault       (out_fault)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    // Cache model: registered read, byte-masked write; not cleared by rst_n.
    logic [31:0] cache_mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) cache_mem[i] = 32'd0;
        mem_read_data = 32'd0;
    end
    always @(posedge clk) begin
        mem_read_data <= cache_mem[mem_address[7:2]];
        if (mem_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_enable[b])
                    cache_mem[mem_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        chk_res;
        logic        wrd;
        logic        fault;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic watch_we     = 1'b0;
    logic we_seen      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (watch_we && mem_enable) we_seen = 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_write_rd", {31'd0, out_write_rd}, {31'd0, e.wrd});
                chk("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
                if (e.chk_res) chk("out_result", out_result, e.result);
                if (e.lat > 0)
                    chk("latency", 32'(($time - e.t_acc + PERIOD/2) / PERIOD), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic wrd,
                         input logic [31:0] exp_res, input logic chk_res,
                         input logic exp_fault, input int exp_lat, input logic push);
        exp_t e;
        int n;
        in_valid      = 1'b1;
        in_is_load    = ld;
        in_is_store   = st;
        in_funct3     = f3;
        in_alu_result = addr;
        in_store_data = sdata;
        in_rd         = rd;
        in_write_rd   = wrd;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        e.rd      = rd;
        e.result  = exp_res;
        e.chk_res = chk_res;
        e.wrd     = exp_fault ? 1'b0 : (ld ? 1'b1 : (st ? 1'b0 : wrd));
        e.fault   = exp_fault;
        e.lat     = exp_lat;
        e.t_acc   = $time;
        if (push) sb.push_back(e);
        #1;
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'd0; in_alu_result = 32'd0; in_store_data = 32'd0;
        in_rd = 5'd0; in_write_rd = 1'b0; out_ready = 1'b1;
        #(2*PERIOD + 2);

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: SW then LW
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 0, 32'd0, 0, 0, 2, 1);
        @(negedge clk);
        chk("sw_mem_enable", {31'd0, mem_enable}, 32'd1);
        chk("sw_mem_be", {28'd0, mem_byte_enable}, 32'hF);
        chk("sw_mem_address", mem_address, 32'h10);
        chk("sw_mem_wdata", mem_write_data, 32'hDEADBEEF);
        issue(1, 0, 3'b010, 32'h10, 32'd0, 5'd2, 0, 32'hDEADBEEF, 1, 0, 3, 1);

        // 2: SB into lane 3, then sub-word loads
        issue(0, 1, 3'b000, 32'h13, 32'h00000080, 5'd3, 0, 32'd0, 0, 0, 2, 1);
        @(negedge clk);
        chk("sb_mem_address", mem_address, 32'h10);
        chk("sb_mem_be", {28'd0, mem_byte_enable}, 32'h8);
        chk("sb_mem_wdata", mem_write_data, 32'h80808080);
        issue(1, 0, 3'b000, 32'h13, 32'd0, 5'd4, 0, 32'hFFFFFF80, 1, 0, 3, 1);
        issue(1, 0, 3'b100, 32'h13, 32'd0, 5'd4, 0, 32'h00000080, 1, 0, 3, 1);
        issue(1, 0, 3'b001, 32'h12, 32'd0, 5'd4, 0, 32'hFFFF80AD, 1, 0, 3, 1);
        issue(1, 0, 3'b101, 32'h10, 32'd0, 5'd4, 0, 32'h0000BEEF, 1, 0, 3, 1);

        // 3: faults never touch memory
        watch_we = 1'b1;
        we_seen  = 1'b0;
        issue(0, 1, 3'b001, 32'h11, 32'h1234, 5'd8, 0, 32'd0, 0, 1, 1, 1);
        issue(1, 0, 3'b010, 32'h12, 32'd0, 5'd8, 0, 32'd0, 0, 1, 1, 1);
        issue(1, 0, 3'b011, 32'h00, 32'd0, 5'd8, 0, 32'd0, 0, 1, 1, 1);
        issue(0, 1, 3'b100, 32'h00, 32'h55, 5'd8, 0, 32'd0, 0, 1, 1, 1);
        step(); step();
        chk("fault_no_write", {31'd0, we_seen}, 32'd0);
        watch_we = 1'b0;

        // 4: output stall on a load
        out_ready = 1'b0;
        issue(1, 0, 3'b010, 32'h10, 32'd0, 5'd7, 0, 32'h80ADBEEF, 1, 0, 0, 1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_result", out_result, 32'h80ADBEEF);
            chk("stall_out_rd", {27'd0, out_rd}, 32'd7);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        issue(0, 0, 3'b000, 32'h0000ABCD, 32'd0, 5'd9, 1, 32'h0000ABCD, 1, 0, 1, 1);

        // 5: back-to-back non-mem ops
        issue(0, 0, 3'b000, 32'h1234, 32'd0, 5'd5, 1, 32'h1234, 1, 0, 1, 1);
        issue(0, 0, 3'b000, 32'h5678, 32'd0, 5'd6, 1, 32'h5678, 1, 0, 1, 1);

        // 6: reset during a store's ACCESS cycle
        issue(0, 1, 3'b010, 32'h20, 32'h11223344, 5'd10, 0, 32'd0, 0, 0, 2, 1);
        issue(0, 1, 3'b010, 32'h20, 32'hFFFFFFFF, 5'd11, 0, 32'd0, 0, 0, 0, 0);
        #1;
        chk("rst6_pre_mem_enable", {31'd0, mem_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst6_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst6_mem_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("rst6_mem_address", mem_address, 32'd0);
        chk("rst6_mem_wdata", mem_write_data, 32'd0);
        chk("rst6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst6_out_fields", {out_rd, out_write_rd, out_fault}, 32'd0);
        chk("rst6_out_result", out_result, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst6_idle_in_ready", {31'd0, in_ready}, 32'd1);
        issue(1, 0, 3'b010, 32'h20, 32'd0, 5'd12, 0, 32'h11223344, 1, 0, 3, 1);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
